// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : conv_pkg
// Description : Shared types and sizing constants for the convolution engine.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int RESULT_W   = 32;
    localparam int MAX_LEN    = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_MAC   = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } convState_t;

    // Product width plus one bit per doubling of the maximum term count.
    function automatic int accWidth(input int dataW, input int addrW);
        return 2 * dataW + addrW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac
// Description : Multiply-accumulate datapath; CONV_SIGNED_EN selects signed math.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = accWidth(DATA_W_DEF, ADDR_W_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic                i_accEn,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [RESULT_W-1:0] o_result
);

    logic [2*DATA_W-1:0] w_aExt;
    logic [2*DATA_W-1:0] w_bExt;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prodExt;
    logic [ACC_W-1:0]    r_acc;

`ifdef CONV_SIGNED_EN
    // Low half of a product of sign-extended operands is the exact signed product.
    assign w_aExt    = {{DATA_W{i_a[DATA_W-1]}}, i_a};
    assign w_bExt    = {{DATA_W{i_b[DATA_W-1]}}, i_b};
    assign w_prod    = w_aExt * w_bExt;
    assign w_prodExt = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign o_result  = {{(RESULT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
`else
    assign w_aExt    = {{DATA_W{1'b0}}, i_a};
    assign w_bExt    = {{DATA_W{1'b0}}, i_b};
    assign w_prod    = w_aExt * w_bExt;
    assign w_prodExt = {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
    assign o_result  = {{(RESULT_W-ACC_W){1'b0}}, r_acc};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_accEn) begin
                r_acc <= r_acc + w_prodExt;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_engine
// Description : Sequential 1-D convolution Z = X (*) Y over sync-read memories.
//               Define CONV_SIGNED_EN for two's complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_s,
    input  logic                start,
    input  logic [ADDR_W:0]     size_x,
    input  logic [ADDR_W:0]     size_y,
    output logic [ADDR_W-1:0]   memx_addr,
    input  logic [DATA_W-1:0]   memx_data,
    output logic [ADDR_W-1:0]   memy_addr,
    input  logic [DATA_W-1:0]   memy_data,
    output logic [ADDR_W:0]     memz_addr,
    output logic [RESULT_W-1:0] memz_data,
    output logic                memz_wr,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int                c_cntW   = ADDR_W + 2;
    localparam logic [ADDR_W:0]   c_maxLen = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [c_cntW-1:0] c_one    = c_cntW'(1);
    localparam logic [c_cntW-1:0] c_two    = c_cntW'(2);

    convState_t          r_state;
    logic [ADDR_W:0]     r_nx;
    logic [ADDR_W:0]     r_ny;
    logic [c_cntW-1:0]   r_k;
    logic [c_cntW-1:0]   r_i;
    logic [ADDR_W-1:0]   r_xAddr;
    logic [ADDR_W-1:0]   r_yAddr;
    logic [ADDR_W:0]     r_zAddr;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_wr;

    logic [c_cntW-1:0]   w_nx;
    logic [c_cntW-1:0]   w_ny;
    logic [c_cntW-1:0]   w_iStart;
    logic [c_cntW-1:0]   w_iEnd;
    logic [c_cntW-1:0]   w_iInc;
    logic [c_cntW-1:0]   w_kLast;
    logic                w_sizeOk;
    logic                w_accClr;
    logic                w_accEn;

    assign w_nx     = c_cntW'(r_nx);
    assign w_ny     = c_cntW'(r_ny);
    // Term range for output k: i in [max(0,k-Ny+1), min(k,Nx-1)].
    assign w_iStart = (r_k + c_one > w_ny) ? (r_k + c_one - w_ny) : '0;
    assign w_iEnd   = (r_k < w_nx - c_one) ? r_k : (w_nx - c_one);
    assign w_iInc   = r_i + c_one;
    assign w_kLast  = w_nx + w_ny - c_two;
    assign w_sizeOk = (size_x != '0) && (size_x <= c_maxLen) &&
                      (size_y != '0) && (size_y <= c_maxLen);

    assign w_accClr = (r_state == ST_CLEAR);
    assign w_accEn  = (r_state == ST_MAC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_nx    <= '0;
            r_ny    <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_xAddr <= '0;
            r_yAddr <= '0;
            r_zAddr <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wr    <= 1'b0;
        end else if (en_s) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_wr   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_sizeOk) begin
                            r_nx    <= size_x;
                            r_ny    <= size_y;
                            r_k     <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_CLEAR;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_i     <= w_iStart;
                    r_xAddr <= w_iStart[ADDR_W-1:0];
                    r_yAddr <= ADDR_W'(r_k - w_iStart);
                    r_state <= ST_READ;
                end
                ST_READ: begin
                    r_state <= ST_MAC;
                end
                ST_MAC: begin
                    if (r_i == w_iEnd) begin
                        r_wr    <= 1'b1;
                        r_zAddr <= r_k[ADDR_W:0];
                        r_state <= ST_WRITE;
                    end else begin
                        r_i     <= w_iInc;
                        r_xAddr <= w_iInc[ADDR_W-1:0];
                        r_yAddr <= ADDR_W'(r_k - w_iInc);
                        r_state <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (r_k == w_kLast) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_k     <= r_k + c_one;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (accWidth(DATA_W, ADDR_W))
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_en     (en_s),
        .i_clr    (w_accClr),
        .i_accEn  (w_accEn),
        .i_a      (memx_data),
        .i_b      (memy_data),
        .o_result (memz_data)
    );

    // Pulses are held in their registers while disabled and reappear on re-enable.
    assign memx_addr = r_xAddr;
    assign memy_addr = r_yAddr;
    assign memz_addr = r_zAddr;
    assign memz_wr   = r_wr & en_s;
    assign done      = r_done & en_s;
    assign err       = r_err & en_s;
    assign busy      = r_busy;

endmodule
`default_nettype wire
